// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor and its resolver.
// Holds default sizes, the 2-bit counter ceiling and counter state names.
package bp_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 16;

    // Ceiling of the predictor's 2-bit saturating counter.
    localparam logic [1:0] SAT_MAX = 2'b11;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_state_e;

endpackage

// File: rtl/pred_fifo.sv
// Generic 1-bit-wide synchronous FIFO holding in-flight predictions.
// Ports: clk, rst_n (sync, active-low), i_push/i_din, i_pop, i_clear,
//        o_dout (head entry), o_full, o_empty, o_count (occupancy).
module pred_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_din,
    input  logic          i_pop,
    input  logic          i_clear,
    output logic          o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_head];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Occupancy is its own counter so full/empty never alias when
    // the pointers meet; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= i_din;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves queued branch predictions against execute outcomes and
// drives the predictor update, the mispredict/flush pulse and stats.
// Ports: clk, rst_n (sync, active-low); pred_valid/pred_taken/pred_ready
//        from the predictor; res_valid/res_taken from execute;
//        upd_result/upd_taken to the predictor; mispredict, flush,
//        outstanding, underflow_err, branch_cnt, miss_cnt.
module branch_resolver
    import bp_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W,
    localparam int OW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_valid,
    input  logic             pred_taken,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             upd_result,
    output logic             upd_taken,
    output logic             mispredict,
    output logic             flush,
    output logic [OW-1:0]    outstanding,
    output logic             underflow_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    logic w_head;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_fire;
    logic w_miss;
    logic w_uflow;

    logic             r_upd_result;
    logic             r_upd_taken;
    logic             r_miss;
    logic             r_uflow;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    assign pred_ready = !w_full;
    assign w_push     = pred_valid && pred_ready;

    assign w_fire  = res_valid && !w_empty;
    assign w_miss  = w_fire && (res_taken != w_head);
    assign w_uflow = res_valid && w_empty;

    // A mispredict squashes every younger entry, including one being
    // pushed this very cycle: those predictions are wrong-path.
    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (pred_taken),
        .i_pop   (w_fire),
        .i_clear (w_miss),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (outstanding)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_upd_result <= 1'b0;
            r_upd_taken  <= 1'b0;
            r_miss       <= 1'b0;
            r_uflow      <= 1'b0;
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_upd_result <= w_fire;
            r_upd_taken  <= w_fire && res_taken;
            r_miss       <= w_miss;
            if (w_uflow) begin
                r_uflow <= 1'b1;
            end
            if (w_fire && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_miss && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign upd_result    = r_upd_result;
    assign upd_taken     = r_upd_taken;
    assign mispredict    = r_miss;
    assign flush         = r_miss;
    assign underflow_err = r_uflow;
    assign branch_cnt    = r_branch_cnt;
    assign miss_cnt      = r_miss_cnt;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench: two resolvers (CNT_W=16 and CNT_W=2) share one
// stimulus stream and are compared against a queue-based model.
module tb_branch_resolver;

    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pred_valid = 1'b0;
    logic pred_taken = 1'b0;
    logic res_valid = 1'b0;
    logic res_taken = 1'b0;

    logic          a_ready, a_upd, a_updt, a_mis, a_fl, a_uf;
    logic [OW-1:0] a_out;
    logic [15:0]   a_bc, a_mc;
    logic          b_ready, b_upd, b_updt, b_mis, b_fl, b_uf;
    logic [OW-1:0] b_out;
    logic [1:0]    b_bc, b_mc;

    always #5 clk = ~clk;

    branch_resolver #(.DEPTH(DEPTH), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_ready(a_ready),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_result(a_upd), .upd_taken(a_updt),
        .mispredict(a_mis), .flush(a_fl),
        .outstanding(a_out), .underflow_err(a_uf),
        .branch_cnt(a_bc), .miss_cnt(a_mc)
    );

    branch_resolver #(.DEPTH(DEPTH), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_ready(b_ready),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_result(b_upd), .upd_taken(b_updt),
        .mispredict(b_mis), .flush(b_fl),
        .outstanding(b_out), .underflow_err(b_uf),
        .branch_cnt(b_bc), .miss_cnt(b_mc)
    );

    // Reference model: in-flight predictions as a plain queue.
    bit q[$];
    int m_bc = 0;
    int m_mc = 0;
    bit m_uf = 0;
    bit m_upd = 0;
    bit m_updt = 0;
    bit m_mis = 0;
    int n_drop = 0;

    int n_pass = 0;
    int n_total = 0;

    function automatic int sat(int v, int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_regs();
        chk("upd_a", 32'(a_upd), 32'(m_upd));
        chk("upd_b", 32'(b_upd), 32'(m_upd));
        if (m_upd) begin
            chk("updt_a", 32'(a_updt), 32'(m_updt));
            chk("updt_b", 32'(b_updt), 32'(m_updt));
        end
        chk("mis_a", 32'(a_mis), 32'(m_mis));
        chk("flush_a", 32'(a_fl), 32'(m_mis));
        chk("mis_b", 32'(b_mis), 32'(m_mis));
        chk("flush_b", 32'(b_fl), 32'(m_mis));
        chk("uf_a", 32'(a_uf), 32'(m_uf));
        chk("uf_b", 32'(b_uf), 32'(m_uf));
        chk("bcnt_a", 32'(a_bc), sat(m_bc, 16));
        chk("mcnt_a", 32'(a_mc), sat(m_mc, 16));
        chk("bcnt_b", 32'(b_bc), sat(m_bc, 2));
        chk("mcnt_b", 32'(b_mc), sat(m_mc, 2));
    endtask

    task automatic chk_occ();
        chk("ready_a", 32'(a_ready), 32'(q.size() != DEPTH));
        chk("ready_b", 32'(b_ready), 32'(q.size() != DEPTH));
        chk("occ_a", 32'(a_out), q.size());
        chk("occ_b", 32'(b_out), q.size());
    endtask

    // One clock: drive inputs, check occupancy, advance model and DUT.
    task automatic step(bit rst, bit pv, bit pt, bit rv, bit rt);
        bit ready;
        bit pushed;
        bit h;
        rst_n      = !rst;
        pred_valid = pv;
        pred_taken = pt;
        res_valid  = rv;
        res_taken  = rt;
        #1;
        chk_occ();
        ready  = (q.size() != DEPTH);
        m_upd  = 0;
        m_updt = 0;
        m_mis  = 0;
        if (rst) begin
            q.delete();
            m_bc = 0;
            m_mc = 0;
            m_uf = 0;
        end else begin
            pushed = pv && ready;
            if (pv && !ready) n_drop++;
            if (rv) begin
                if (q.size() == 0) begin
                    m_uf = 1;
                end else begin
                    h      = q.pop_front();
                    m_upd  = 1;
                    m_updt = rt;
                    m_mis  = (rt != h);
                    m_bc++;
                    if (m_mis) m_mc++;
                end
            end
            if (m_mis) q.delete();
            else if (pushed) q.push_back(pt);
        end
        @(posedge clk);
        #1;
        chk_regs();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_regs();
        chk_occ();

        // In-order correct resolution.
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Mispredict flushes younger entries; later resolve underflows.
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0);

        // Fill, drop when full, pop+push while full.
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 1);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1);

        // Mispredict with a push in the same cycle discards the push.
        step(0, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Underflow with a simultaneous push; push is kept.
        step(0, 1, 1, 1, 0);
        step(0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Reset mid-stream with a resolve pending.
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);

        // Five correct resolutions saturate the 2-bit counters.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 1, 0);
        end
        step(0, 0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) < 6),
                 1'($urandom),
                 ($urandom_range(0, 1) == 1),
                 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
